// File: rtl/enc_lag3_pipe.sv
// Closed-loop pitch lag encoder (G.729 style).
// Encodes integer lag + fraction into the pitch index and maintains the
// T0_min/T0_max search window between subframes. Fixed 4-cycle latency from
// the start-sampling edge to done, with a start/done handshake.
module enc_lag3_pipe #(
  parameter int unsigned PIT_MIN = 20,
  parameter int unsigned PIT_MAX = 143,
  parameter int unsigned W       = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         pit_flag_i,
  input  logic [W-1:0] t0_i,
  input  logic [W-1:0] t0_frac_i,
  output logic         done_o,
  output logic [W-1:0] pitch_index_o,
  output logic [W-1:0] t0_min_o,
  output logic [W-1:0] t0_max_o
);

  // Intermediates carry two guard bits so 3*T0 and friends never wrap.
  localparam int unsigned LagW = W + 2;

  localparam logic signed [LagW-1:0] PitMinS  = LagW'(PIT_MIN);
  localparam logic signed [LagW-1:0] PitMaxS  = LagW'(PIT_MAX);
  localparam logic signed [LagW-1:0] WinLoS   = LagW'(5);
  localparam logic signed [LagW-1:0] WinSpanS = LagW'(9);
  localparam logic signed [LagW-1:0] Sf0OffS  = LagW'(58);
  localparam logic signed [LagW-1:0] Sf0HiOfS = LagW'(112);
  localparam logic signed [LagW-1:0] Sf0KneeS = LagW'(85);
  localparam logic signed [LagW-1:0] Sf1OffS  = LagW'(2);

  typedef enum logic [2:0] {
    StIdle,
    StCalcIdx,
    StCalcMin,
    StCalcMax,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operands latched at the accepted start so inputs may change afterwards.
  logic [W-1:0] t0_q, t0_d;
  logic [W-1:0] frac_q, frac_d;
  logic         flag_q, flag_d;

  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] pitch_index_q, pitch_index_d;
  logic [W-1:0] t0_min_q, t0_min_d;
  logic [W-1:0] t0_max_q, t0_max_d;
  logic         done_q, done_d;

  // Signed, widened views of the operands and current window.
  logic signed [LagW-1:0] t0_s;
  logic signed [LagW-1:0] frac_s;
  logic signed [LagW-1:0] min_s;
  logic signed [LagW-1:0] idx_sf0;
  logic signed [LagW-1:0] idx_sf1;
  logic signed [LagW-1:0] idx_full;
  logic signed [LagW-1:0] min_raw;
  logic signed [LagW-1:0] min_clamped;
  logic signed [LagW-1:0] max_raw;
  logic signed [LagW-1:0] min_from_max;

  // Index and window candidates, derived from the latched operands.
  always_comb begin
    t0_s   = signed'({{2{t0_q[W-1]}}, t0_q});
    frac_s = signed'({{2{frac_q[W-1]}}, frac_q});
    min_s  = signed'({{2{t0_min_q[W-1]}}, t0_min_q});

    // Subframe 0: fine resolution below the knee, integer resolution above.
    if (t0_s <= Sf0KneeS) begin
      idx_sf0 = (t0_s <<< 1) + t0_s - Sf0OffS + frac_s;
    end else begin
      idx_sf0 = t0_s + Sf0HiOfS;
    end

    // Subframe 1: relative to the stored window lower bound.
    idx_sf1  = ((t0_s - min_s) <<< 1) + (t0_s - min_s) + Sf1OffS + frac_s;
    idx_full = flag_q ? idx_sf1 : idx_sf0;

    min_raw      = t0_s - WinLoS;
    min_clamped  = (min_raw < PitMinS) ? PitMinS : min_raw;
    max_raw      = min_s + WinSpanS;
    min_from_max = PitMaxS - WinSpanS;
  end

  // Guard bits are dropped on purpose: outputs are truncated to W bits.
  logic unused_guard;
  assign unused_guard = ^{idx_full[LagW-1:W], min_clamped[LagW-1:W],
                          min_from_max[LagW-1:W]};

  // Next-state and datapath updates for each FSM step.
  always_comb begin
    state_d       = state_q;
    t0_d          = t0_q;
    frac_d        = frac_q;
    flag_d        = flag_q;
    idx_d         = idx_q;
    pitch_index_d = pitch_index_q;
    t0_min_d      = t0_min_q;
    t0_max_d      = t0_max_q;
    done_d        = done_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          t0_d    = t0_i;
          frac_d  = t0_frac_i;
          flag_d  = pit_flag_i;
          done_d  = 1'b0;
          state_d = StCalcIdx;
        end
      end
      StCalcIdx: begin
        idx_d   = idx_full[W-1:0];
        state_d = StCalcMin;
      end
      StCalcMin: begin
        if (!flag_q) begin
          t0_min_d = min_clamped[W-1:0];
        end
        state_d = StCalcMax;
      end
      StCalcMax: begin
        // Uses the T0_min written in the previous step.
        if (!flag_q) begin
          if (max_raw > PitMaxS) begin
            t0_max_d = PitMaxS[W-1:0];
            t0_min_d = min_from_max[W-1:0];
          end else begin
            t0_max_d = max_raw[W-1:0];
          end
        end
        state_d = StDone;
      end
      StDone: begin
        pitch_index_d = idx_q;
        done_d        = 1'b1;
        state_d       = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register; reset aborts any encode in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      t0_q          <= '0;
      frac_q        <= '0;
      flag_q        <= 1'b0;
      idx_q         <= '0;
      pitch_index_q <= '0;
      t0_min_q      <= PitMinS[W-1:0];
      t0_max_q      <= W'(PIT_MIN + 9);
      done_q        <= 1'b0;
    end else begin
      t0_q          <= t0_d;
      frac_q        <= frac_d;
      flag_q        <= flag_d;
      idx_q         <= idx_d;
      pitch_index_q <= pitch_index_d;
      t0_min_q      <= t0_min_d;
      t0_max_q      <= t0_max_d;
      done_q        <= done_d;
    end
  end

  assign done_o        = done_q;
  assign pitch_index_o = pitch_index_q;
  assign t0_min_o      = t0_min_q;
  assign t0_max_o      = t0_max_q;

endmodule

// File: tb/tb_enc_lag3_pipe.sv
// Directed bench for enc_lag3_pipe with hand-computed expected values.
module tb_enc_lag3_pipe;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         pit_flag;
  logic [W-1:0] t0;
  logic [W-1:0] t0_frac;
  logic         done;
  logic [W-1:0] pitch_index;
  logic [W-1:0] t0_min;
  logic [W-1:0] t0_max;

  int n_checks = 0;
  int n_errors = 0;

  enc_lag3_pipe #(
    .PIT_MIN(20),
    .PIT_MAX(143),
    .W      (W)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .pit_flag_i   (pit_flag),
    .t0_i         (t0),
    .t0_frac_i    (t0_frac),
    .done_o       (done),
    .pitch_index_o(pitch_index),
    .t0_min_o     (t0_min),
    .t0_max_o     (t0_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one encode, scramble inputs after the start edge, and wait for done.
  // Optionally pulse start mid-encode (must be ignored).
  task automatic run_encode(input string tag, input int lag, input int frac, input logic flag,
                            input logic poke_busy);
    int cyc;
    @(negedge clk);
    t0       = W'(lag);
    t0_frac  = W'(frac);
    pit_flag = flag;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    t0       = 16'd99;
    t0_frac  = 16'd0;
    pit_flag = ~flag;
    check_eq({tag, " done cleared"}, int'(done), 0);
    cyc = 0;
    while (!done && cyc < 10) begin
      if (poke_busy && cyc == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check_eq({tag, " latency"}, cyc, 4);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pit_flag = 1'b0;
    t0       = '0;
    t0_frac  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("reset done", int'(done), 0);
    check_eq("reset index", int'(pitch_index), 0);
    check_eq("reset min", int'(t0_min), 20);
    check_eq("reset max", int'(t0_max), 29);

    // 1: subframe 0, below knee.
    run_encode("t1", 60, 0, 1'b0, 1'b0);
    check_eq("t1 index", int'(pitch_index), 122);
    check_eq("t1 min", int'(t0_min), 55);
    check_eq("t1 max", int'(t0_max), 64);

    // 2: subframe 1 relative to stored window.
    run_encode("t2", 62, 1, 1'b1, 1'b0);
    check_eq("t2 index", int'(pitch_index), 24);
    check_eq("t2 min", int'(t0_min), 55);
    check_eq("t2 max", int'(t0_max), 64);

    // 3: low clamp.
    run_encode("t3", 22, -1, 1'b0, 1'b0);
    check_eq("t3 index", int'(pitch_index), 7);
    check_eq("t3 min", int'(t0_min), 20);
    check_eq("t3 max", int'(t0_max), 29);

    // 4: high clamp.
    run_encode("t4", 140, 0, 1'b0, 1'b0);
    check_eq("t4 index", int'(pitch_index), 252);
    check_eq("t4 min", int'(t0_min), 134);
    check_eq("t4 max", int'(t0_max), 143);

    // 5: both sides of the knee; mid-encode start must be ignored.
    run_encode("t5a", 85, 1, 1'b0, 1'b1);
    check_eq("t5a index", int'(pitch_index), 198);
    check_eq("t5a min", int'(t0_min), 80);
    check_eq("t5a max", int'(t0_max), 89);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5a done held", int'(done), 1);
    check_eq("t5a index held", int'(pitch_index), 198);
    run_encode("t5b", 86, 0, 1'b0, 1'b0);
    check_eq("t5b index", int'(pitch_index), 198);
    check_eq("t5b min", int'(t0_min), 81);
    check_eq("t5b max", int'(t0_max), 90);

    // 6: reset while in CALC_MIN.
    @(negedge clk);
    t0       = 16'd100;
    t0_frac  = 16'd0;
    pit_flag = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("t6 done", int'(done), 0);
    check_eq("t6 index", int'(pitch_index), 0);
    check_eq("t6 min", int'(t0_min), 20);
    check_eq("t6 max", int'(t0_max), 29);
    repeat (6) @(posedge clk);
    #1;
    check_eq("t6 no stale done", int'(done), 0);

    // Subframe 1 after reset uses the reset window: 3*(25-20)+2+0 = 17.
    run_encode("t7", 25, 0, 1'b1, 1'b0);
    check_eq("t7 index", int'(pitch_index), 17);
    check_eq("t7 min", int'(t0_min), 20);
    check_eq("t7 max", int'(t0_max), 29);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
